// File: rtl/mmu_8722.sv
// C128 memory management unit: configuration registers, PLA mode selects and
// CPU/VIC high-address translation with common-RAM and zero/stack page relocation.
module mmu_8722 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    input  logic        rw,
    input  logic        aec,
    input  logic        acc,
    input  logic        game_in,
    input  logic        exrom_in,
    input  logic        sense40,
    output logic [7:0]  dout,
    output logic        dout_oe,
    output logic        ms0,
    output logic        ms1,
    output logic        ms2,
    output logic        ms3,
    output logic        z80en,
    output logic        fsdir,
    output logic [7:0]  ta,
    output logic [1:0]  ram_bank
);

    logic [7:0]  cr;
    logic [7:0]  pcr [4];
    logic        mcr_c64;
    logic        mcr_fsdir;
    logic        mcr_z80;
    logic [7:0]  rcr;
    logic [7:0]  p0_page;
    logic [7:0]  p1_page;
    logic [1:0]  p0_bank;
    logic [1:0]  p1_bank;
    logic [1:0]  p0_stage;
    logic [1:0]  p1_stage;

    logic        hit_d5;
    logic        hit_ff;
    logic        decoded;
    logic        wr_en;
    logic [1:0]  pidx;
    logic [7:0]  rd_data;
    logic [16:0] common_size;
    logic        common_hit;

    // $D501-$D504 and $FF01-$FF04 both map address 1..4 onto PCR 0..3;
    // subtracting one in two bits wraps address 4 onto index 3.
    assign pidx = a[1:0] - 2'd1;

    assign hit_ff  = !mcr_c64 && (a[15:8] == 8'hFF) && (a[7:0] <= 8'h04);
    assign hit_d5  = !mcr_c64 && !cr[0] && (a[15:8] == 8'hD5) && (a[7:0] <= 8'h0B);
    assign decoded = hit_ff || hit_d5;

    // acc is a one-clk commit strobe: a write lands only on the edge where
    // acc is high during a CPU-owned (aec) write (!rw) to a decoded register.
    assign wr_en = acc && aec && !rw && decoded;

    always_ff @(posedge clk) begin
        if (rst) begin
            cr        <= 8'h00;
            for (int i = 0; i < 4; i++) pcr[i] <= 8'h00;
            mcr_c64   <= 1'b0;
            mcr_fsdir <= 1'b0;
            mcr_z80   <= 1'b0;
            rcr       <= 8'h00;
            p0_page   <= 8'h00;
            p1_page   <= 8'h01;
            p0_bank   <= 2'd0;
            p1_bank   <= 2'd0;
            p0_stage  <= 2'd0;
            p1_stage  <= 2'd0;
        end else if (wr_en) begin
            if (hit_ff) begin
                // Load-configuration writes copy a preset; the data bus is ignored.
                if (a[2:0] == 3'd0) cr <= din;
                else                cr <= pcr[pidx];
            end else begin
                case (a[3:0])
                    4'h0: cr <= din;
                    4'h1, 4'h2, 4'h3, 4'h4: pcr[pidx] <= din;
                    4'h5: begin
                        mcr_c64   <= din[6];
                        mcr_fsdir <= din[3];
                        mcr_z80   <= din[0];
                    end
                    4'h6: rcr <= din;
                    4'h7: begin
                        p0_page <= din;
                        p0_bank <= p0_stage;
                    end
                    4'h8: p0_stage <= din[1:0];
                    4'h9: begin
                        p1_page <= din;
                        p1_bank <= p1_stage;
                    end
                    4'hA: p1_stage <= din[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (hit_ff) begin
            rd_data = (a[2:0] == 3'd0) ? cr : pcr[pidx];
        end else if (hit_d5) begin
            case (a[3:0])
                4'h0: rd_data = cr;
                4'h1, 4'h2, 4'h3, 4'h4: rd_data = pcr[pidx];
                4'h5: rd_data = {sense40, mcr_c64, exrom_in, game_in, mcr_fsdir, 2'b11, mcr_z80};
                4'h6: rd_data = rcr;
                4'h7: rd_data = p0_page;
                4'h8: rd_data = {6'b0, p0_bank};
                4'h9: rd_data = p1_page;
                4'hA: rd_data = {6'b0, p1_bank};
                4'hB: rd_data = 8'h20;
                default: rd_data = 8'h00;
            endcase
        end
    end

    assign dout_oe = aec && rw && decoded;
    assign dout    = dout_oe ? rd_data : 8'h00;

    assign ms3   = !mcr_c64;
    assign ms2   = cr[0];
    assign z80en = mcr_z80;
    assign fsdir = mcr_fsdir;

    always_comb begin
        {ms1, ms0} = 2'b11;
        case (a[15:14])
            2'b00: {ms1, ms0} = 2'b11;
            2'b01: {ms1, ms0} = cr[1] ? 2'b11 : 2'b00;
            2'b10: {ms1, ms0} = {cr[2], cr[3]};
            2'b11: {ms1, ms0} = {cr[4], cr[5]};
            default: {ms1, ms0} = 2'b11;
        endcase
    end

    always_comb begin
        common_size = 17'h00400;
        case (rcr[1:0])
            2'd0: common_size = 17'h00400;
            2'd1: common_size = 17'h01000;
            2'd2: common_size = 17'h02000;
            2'd3: common_size = 17'h04000;
            default: common_size = 17'h00400;
        endcase
    end

    assign common_hit = (rcr[2] && ({1'b0, a} < common_size)) ||
                        (rcr[3] && ({1'b0, a} >= (17'h10000 - common_size)));

    // VIC fetches bypass relocation entirely and take their bank from RCR.
    always_comb begin
        ta       = a[15:8];
        ram_bank = cr[7:6];
        if (!aec) begin
            ram_bank = rcr[7:6];
        end else if (common_hit) begin
            ram_bank = 2'd0;
        end else if (a[15:8] == 8'h00) begin
            ta       = p0_page;
            ram_bank = p0_bank;
        end else if (a[15:8] == 8'h01) begin
            ta       = p1_page;
            ram_bank = p1_bank;
        end else if (a[15:8] == p0_page) begin
            ta       = 8'h00;
            ram_bank = 2'd0;
        end else if (a[15:8] == p1_page) begin
            ta       = 8'h01;
            ram_bank = 2'd0;
        end
    end

endmodule

// File: tb/tb_mmu_8722.sv
// Bench for mmu_8722: reset-state vector table, directed sequences and random
// bus traffic compared against an address-level model of the register map.
module tb_mmu_8722;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  din;
    logic        rw;
    logic        aec;
    logic        acc;
    logic        game_in;
    logic        exrom_in;
    logic        sense40;
    logic [7:0]  dout;
    logic        dout_oe;
    logic        ms0, ms1, ms2, ms3;
    logic        z80en;
    logic        fsdir;
    logic [7:0]  ta;
    logic [1:0]  ram_bank;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [24:0] exp_q[$];

    mmu_8722 dut (
        .clk(clk), .rst(rst), .a(a), .din(din), .rw(rw), .aec(aec), .acc(acc),
        .game_in(game_in), .exrom_in(exrom_in), .sense40(sense40),
        .dout(dout), .dout_oe(dout_oe),
        .ms0(ms0), .ms1(ms1), .ms2(ms2), .ms3(ms3),
        .z80en(z80en), .fsdir(fsdir), .ta(ta), .ram_bank(ram_bank)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model state
    logic [7:0] m_cr, m_mcr, m_rcr, m_p0pg, m_p1pg;
    logic [7:0] m_pcr [4];
    logic [1:0] m_p0bk, m_p1bk, m_p0h, m_p1h;

    function automatic void model_reset();
        m_cr = 8'h00; m_mcr = 8'h00; m_rcr = 8'h00;
        for (int i = 0; i < 4; i++) m_pcr[i] = 8'h00;
        m_p0pg = 8'h00; m_p1pg = 8'h01;
        m_p0bk = 2'd0; m_p1bk = 2'd0; m_p0h = 2'd0; m_p1h = 2'd0;
    endfunction

    function automatic bit model_visible(input logic [15:0] ad);
        if (m_mcr[6]) return 1'b0;
        if (ad >= 16'hFF00 && ad <= 16'hFF04) return 1'b1;
        if (ad >= 16'hD500 && ad <= 16'hD50B && !m_cr[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_write(input logic [15:0] ad, input logic [7:0] d);
        int off;
        if (!model_visible(ad)) return;
        if (ad >= 16'hFF00) begin
            off = int'(ad) - 'hFF00;
            if (off == 0) m_cr = d;
            else          m_cr = m_pcr[off - 1];
        end else begin
            off = int'(ad) - 'hD500;
            case (off)
                0: m_cr = d;
                1, 2, 3, 4: m_pcr[off - 1] = d;
                5: m_mcr = d & 8'h49;
                6: m_rcr = d;
                7: begin m_p0pg = d; m_p0bk = m_p0h; end
                8: m_p0h = d[1:0];
                9: begin m_p1pg = d; m_p1bk = m_p1h; end
                10: m_p1h = d[1:0];
                default: ;
            endcase
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] ad);
        int off;
        if (ad >= 16'hFF00) begin
            off = int'(ad) - 'hFF00;
            return (off == 0) ? m_cr : m_pcr[off - 1];
        end
        off = int'(ad) - 'hD500;
        case (off)
            0: return m_cr;
            1, 2, 3, 4: return m_pcr[off - 1];
            5: return {sense40, m_mcr[6], exrom_in, game_in, m_mcr[3], 2'b11, m_mcr[0]};
            6: return m_rcr;
            7: return m_p0pg;
            8: return {6'b0, m_p0bk};
            9: return m_p1pg;
            10: return {6'b0, m_p1bk};
            11: return 8'h20;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [24:0] model_expect(input logic [15:0] ad, input logic aec_v, input logic rw_v);
        logic       oe;
        logic [7:0] dt, t;
        logic [1:0] ms10, b;
        int         sz, pg, quad;
        bit         common;
        oe   = aec_v && rw_v && model_visible(ad);
        dt   = oe ? model_read(ad) : 8'h00;
        quad = int'(ad) / 16384;
        pg   = int'(ad) / 256;
        case (quad)
            0: ms10 = 2'b11;
            1: ms10 = m_cr[1] ? 2'b11 : 2'b00;
            2: ms10 = {m_cr[2], m_cr[3]};
            default: ms10 = {m_cr[4], m_cr[5]};
        endcase
        case (m_rcr[1:0])
            2'd0: sz = 1024;
            2'd1: sz = 4096;
            2'd2: sz = 8192;
            default: sz = 16384;
        endcase
        common = (m_rcr[2] && int'(ad) < sz) || (m_rcr[3] && int'(ad) >= 65536 - sz);
        t = pg[7:0];
        b = m_cr[7:6];
        if (!aec_v)                  b = m_rcr[7:6];
        else if (common)             b = 2'd0;
        else if (pg == 0)            begin t = m_p0pg; b = m_p0bk; end
        else if (pg == 1)            begin t = m_p1pg; b = m_p1bk; end
        else if (pg == int'(m_p0pg)) begin t = 8'h00; b = 2'd0; end
        else if (pg == int'(m_p1pg)) begin t = 8'h01; b = 2'd0; end
        return {oe, dt, !m_mcr[6], m_cr[0], ms10, m_mcr[0], m_mcr[3], t, b};
    endfunction

    // scoreboard
    task automatic compare_now(input string name);
        logic [24:0] exp_v, act_v;
        exp_q.push_back(model_expect(a, aec, rw));
        exp_v = exp_q.pop_front();
        act_v = {dout_oe, dout, ms3, ms2, ms1, ms0, z80en, fsdir, ta, ram_bank};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (oe,dout,ms3..0,z80,fsdir,ta,bank)", name, act_v, exp_v);
        end
    endtask

    task automatic check_val(input string name, input int act_v, input int exp_v);
        n_cmp++;
        if (act_v != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act_v, exp_v);
        end
    endtask

    // drivers
    task automatic bus_cycle(input logic [15:0] ad, input logic [7:0] d, input logic rw_v,
                             input logic aec_v, input logic acc_v, input string name);
        @(negedge clk);
        a = ad; din = d; rw = rw_v; aec = aec_v; acc = acc_v;
        #1;
        compare_now(name);
        @(posedge clk);
        #1;
        if (acc_v && aec_v && !rw_v) model_write(ad, d);
        acc = 1'b0;
        rw  = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] ad, input logic [7:0] d);
        bus_cycle(ad, d, 1'b0, 1'b1, 1'b1, $sformatf("wr_%h", ad));
    endtask

    task automatic look(input logic [15:0] ad, input logic aec_v);
        bus_cycle(ad, 8'h00, 1'b1, aec_v, 1'b0, $sformatf("rd_%h_aec%0d", ad, aec_v));
    endtask

    task automatic reset_cycle(input bit with_write, input logic [15:0] ad, input logic [7:0] d);
        @(negedge clk);
        rst = 1'b1; a = ad; din = d; aec = 1'b1;
        rw  = with_write ? 1'b0 : 1'b1;
        acc = with_write;
        @(posedge clk);
        #1;
        rst = 1'b0; acc = 1'b0; rw = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [15:0] a;
        logic        aec;
        logic        rw;
        logic        oe;
        logic [7:0]  dout;
        logic [7:0]  ta;
        logic [1:0]  ms10;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{16'hD50B, 1'b1, 1'b1, 1'b1, 8'h20, 8'hD5, 2'b00};
        vecs[1]  = '{16'hD506, 1'b1, 1'b1, 1'b1, 8'h00, 8'hD5, 2'b00};
        vecs[2]  = '{16'hD505, 1'b1, 1'b1, 1'b1, 8'h96, 8'hD5, 2'b00};
        vecs[3]  = '{16'hD509, 1'b1, 1'b1, 1'b1, 8'h01, 8'hD5, 2'b00};
        vecs[4]  = '{16'hD50C, 1'b1, 1'b1, 1'b0, 8'h00, 8'hD5, 2'b00};
        vecs[5]  = '{16'hFF00, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 2'b00};
        vecs[6]  = '{16'hFF05, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 2'b00};
        vecs[7]  = '{16'hD50B, 1'b0, 1'b1, 1'b0, 8'h00, 8'hD5, 2'b00};
        vecs[8]  = '{16'hD50B, 1'b1, 1'b0, 1'b0, 8'h00, 8'hD5, 2'b00};
        vecs[9]  = '{16'h0012, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 2'b11};
        vecs[10] = '{16'h0134, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 2'b11};

        rst = 1'b1; a = 16'h0000; din = 8'h00; rw = 1'b1; aec = 1'b1; acc = 1'b0;
        game_in = 1'b1; exrom_in = 1'b0; sense40 = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        look(16'h8000, 1'b1);
        check_val("rst_ms3", ms3, 1);
        check_val("rst_ms2", ms2, 0);
        check_val("rst_z80en", z80en, 0);
        check_val("rst_bank", ram_bank, 0);
        foreach (vecs[i]) begin
            bus_cycle(vecs[i].a, 8'h00, vecs[i].rw, vecs[i].aec, 1'b0, $sformatf("vec%0d", i));
            check_val($sformatf("vec%0d_oe", i), dout_oe, vecs[i].oe);
            check_val($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
            check_val($sformatf("vec%0d_ta", i), ta, vecs[i].ta);
            check_val($sformatf("vec%0d_ms10", i), {ms1, ms0}, vecs[i].ms10);
            check_val($sformatf("vec%0d_bank", i), ram_bank, 0);
        end

        // CR decode and I/O hiding
        bus_write(16'hFF00, 8'h3E);
        look(16'hC123, 1'b1);
        check_val("cr3e_ms10", {ms1, ms0}, 3);
        check_val("cr3e_bank", ram_bank, 0);
        bus_write(16'hFF00, 8'h01);
        look(16'hD505, 1'b1);
        check_val("io_hidden_oe", dout_oe, 0);
        look(16'hFF00, 1'b1);
        check_val("ff00_oe", dout_oe, 1);
        check_val("ff00_dout", dout, 8'h01);

        // PCR preset load; written data must be ignored
        bus_write(16'hFF00, 8'h00);
        bus_write(16'hD502, 8'h7F);
        bus_write(16'hFF02, 8'h00);
        look(16'h8000, 1'b1);
        check_val("pcr_ms10", {ms1, ms0}, 3);
        check_val("pcr_bank", ram_bank, 1);
        look(16'hFF00, 1'b1);
        check_val("pcr_cr", dout, 8'h7F);

        // page pointers: staged bank commits with the page write
        bus_write(16'hFF00, 8'h00);
        bus_write(16'hD508, 8'h01);
        bus_write(16'hD507, 8'h40);
        look(16'h0012, 1'b1);
        check_val("p0_ta", ta, 8'h40);
        check_val("p0_bank", ram_bank, 1);
        look(16'h4012, 1'b1);
        check_val("p0_swap_ta", ta, 8'h00);
        check_val("p0_swap_bank", ram_bank, 0);
        bus_write(16'hD508, 8'h02);
        look(16'h0012, 1'b1);
        check_val("p0h_only_ta", ta, 8'h40);
        check_val("p0h_only_bank", ram_bank, 1);
        look(16'hD508, 1'b1);
        check_val("p0h_committed", dout, 8'h01);

        // common RAM, bottom then top, then VIC bank
        bus_write(16'hD506, 8'h05);
        bus_write(16'hFF00, 8'h40);
        look(16'h0FFF, 1'b1);
        check_val("common_in_bank", ram_bank, 0);
        look(16'h1000, 1'b1);
        check_val("common_out_bank", ram_bank, 1);
        bus_write(16'hD506, 8'h0B);
        look(16'hC000, 1'b1);
        check_val("top_in_bank", ram_bank, 0);
        look(16'hBFFF, 1'b1);
        check_val("top_out_bank", ram_bank, 1);
        bus_write(16'hD506, 8'h8B);
        look(16'hC000, 1'b0);
        check_val("vic_bank", ram_bank, 2);
        check_val("vic_ta", ta, 8'hC0);

        // acc without aec, and acc with rw=1, must not change state
        bus_cycle(16'hFF00, 8'hAA, 1'b0, 1'b0, 1'b1, "acc_no_aec");
        bus_cycle(16'hFF00, 8'hAA, 1'b1, 1'b1, 1'b1, "acc_read");
        look(16'hFF00, 1'b1);
        check_val("acc_guard_cr", dout, 8'h40);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [15:0] ad;
            logic [7:0]  d;
            logic        wr;
            case ($urandom_range(0, 3))
                0: ad = 16'hD500 + 16'($urandom_range(0, 15));
                1: ad = 16'hFF00 + 16'($urandom_range(0, 6));
                2: ad = 16'($urandom_range(0, 3) * 256 + $urandom_range(0, 255));
                default: ad = 16'($urandom_range(0, 65535));
            endcase
            d  = 8'($urandom_range(0, 255));
            if (ad == 16'hD505) d[6] = 1'b0;
            wr = ($urandom_range(0, 1) == 1);
            bus_cycle(ad, d, !wr, ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0),
                      $sformatf("rnd%0d", i));
        end

        // C64 lock
        bus_write(16'hFF00, 8'h00);
        bus_write(16'hD505, 8'h40);
        look(16'hFF00, 1'b1);
        check_val("c64_ms3", ms3, 0);
        check_val("c64_ff00_oe", dout_oe, 0);
        bus_write(16'hFF00, 8'hFF);
        look(16'h0000, 1'b1);
        check_val("c64_cr_locked", ms2, 0);
        bus_write(16'hD505, 8'h00);
        look(16'h0000, 1'b1);
        check_val("c64_sticky", ms3, 0);

        // reset wins over a coincident write
        reset_cycle(1'b1, 16'hFF00, 8'h3E);
        look(16'h8000, 1'b1);
        check_val("rstw_ms3", ms3, 1);
        check_val("rstw_ms2", ms2, 0);
        check_val("rstw_ms10", {ms1, ms0}, 0);
        check_val("rstw_z80en", z80en, 0);
        check_val("rstw_bank", ram_bank, 0);
        look(16'hD506, 1'b1);
        check_val("rstw_rcr", dout, 8'h00);

        // reset mid-staging clears the staged bank
        bus_write(16'hD508, 8'h03);
        reset_cycle(1'b0, 16'h0000, 8'h00);
        bus_write(16'hD507, 8'h22);
        look(16'h0050, 1'b1);
        check_val("stage_clr_ta", ta, 8'h22);
        check_val("stage_clr_bank", ram_bank, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
